// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor control path.
// Covers op codes, the T-state encoding, bus select codes and instruction field positions.
package proc_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned NREG   = 8;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned REG_W  = 3;
   localparam int unsigned SEL_W  = 4;

   // Instruction field positions: op = IR[15:13], X = IR[12:10], Y = IR[9:7]
   localparam int unsigned OP_LSB = 13;
   localparam int unsigned X_LSB  = 10;
   localparam int unsigned Y_LSB  = 7;

   localparam logic [OP_W-1:0] OP_MV  = 3'b000;
   localparam logic [OP_W-1:0] OP_MVI = 3'b001;
   localparam logic [OP_W-1:0] OP_ADD = 3'b010;
   localparam logic [OP_W-1:0] OP_SUB = 3'b011;

   // Bus mux select: 0-7 pick R0-R7; the datapath mux uses these same codes
   localparam logic [SEL_W-1:0] SEL_G    = 4'd8;
   localparam logic [SEL_W-1:0] SEL_DIN  = 4'd9;
   localparam logic [SEL_W-1:0] SEL_IDLE = 4'd15;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   // Decoded part of the instruction word; the low seven bits carry nothing
   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [REG_W-1:0] rx;
      logic [REG_W-1:0] ry;
   } instr_t;

   function automatic logic [NREG-1:0] reg_onehot(input logic [REG_W-1:0] r);
      return NREG'(1) << r;
   endfunction

   function automatic logic [SEL_W-1:0] reg_sel(input logic [REG_W-1:0] r);
      return SEL_W'(r);
   endfunction

   function automatic logic is_arith(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/proc_ir_decode.sv
// Combinational control decode: maps (state, instruction, Run) to datapath strobes
// and the next T-state. Any state/op pair that cannot occur falls back to T0 with every strobe off.
module proc_ir_decode
   import proc_pkg::*;
(
   input  state_t           state,
   input  instr_t           instr,
   input  logic             run,
   output logic             ir_load,
   output logic [NREG-1:0]  rin,
   output logic             ain,
   output logic             gin,
   output logic             add_sub,
   output logic [SEL_W-1:0] bus_sel,
   output logic             done,
   output state_t           state_next
);

   logic arith;
   assign arith = is_arith(instr.op);

   always_comb begin
      ir_load    = 1'b0;
      rin        = '0;
      ain        = 1'b0;
      gin        = 1'b0;
      add_sub    = 1'b0;
      bus_sel    = SEL_IDLE;
      done       = 1'b0;
      state_next = T0;

      case (state)
         T0: begin
            ir_load    = run;
            state_next = run ? T1 : T0;
         end

         T1: begin
            case (instr.op)
               OP_MV: begin
                  bus_sel = reg_sel(instr.ry);
                  rin     = reg_onehot(instr.rx);
                  done    = 1'b1;
               end
               OP_MVI: begin
                  bus_sel = SEL_DIN;
                  rin     = reg_onehot(instr.rx);
                  done    = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  bus_sel    = reg_sel(instr.rx);
                  ain        = 1'b1;
                  state_next = T2;
               end
               // Reserved op codes retire as a NOP
               default: done = 1'b1;
            endcase
         end

         T2: begin
            if (arith) begin
               bus_sel    = reg_sel(instr.ry);
               gin        = 1'b1;
               add_sub    = (instr.op == OP_SUB);
               state_next = T3;
            end
         end

         T3: begin
            if (arith) begin
               bus_sel = SEL_G;
               rin     = reg_onehot(instr.rx);
               done    = 1'b1;
            end
         end

         default: state_next = T0;
      endcase
   end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Processor control unit: holds the T-state register and the instruction register.
// All datapath strobes come combinationally from proc_ir_decode.
module proc_ctrl_fsm
   import proc_pkg::*;
(
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Run,
   input  logic [DATA_W-1:0] DIN,
   output logic              IRin,
   output logic [NREG-1:0]   Rin,
   output logic              Ain,
   output logic              Gin,
   output logic              AddSub,
   output logic [SEL_W-1:0]  BusSel,
   output logic              Done
);

   state_t            state;
   state_t            state_next;
   logic [DATA_W-1:0] ir;
   instr_t            instr;
   logic              ir_load;

   // The operand-free low bits of IR are kept for visibility but never decoded
   logic unused_ir;
   assign unused_ir = ^ir[Y_LSB-1:0];

   assign instr = instr_t'(ir[DATA_W-1:Y_LSB]);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= T0;
         ir    <= '0;
      end else begin
         state <= state_next;
         if (ir_load) ir <= DIN;
      end
   end

   proc_ir_decode u_decode (
      .state      (state),
      .instr      (instr),
      .run        (Run),
      .ir_load    (ir_load),
      .rin        (Rin),
      .ain        (Ain),
      .gin        (Gin),
      .add_sub    (AddSub),
      .bus_sel    (BusSel),
      .done       (Done),
      .state_next (state_next)
   );

   assign IRin = ir_load;

endmodule
